// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge bus between mem_access_unit (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: store lane alignment, load extension, handshake FSM with timeout.
// Defining DMEM_MISALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module mem_access_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_alu_out,
  input  logic [31:0]       mem_reg_data2,
  input  logic [3:0]        mem_data_mem_read,
  input  logic [2:0]        mem_data_mem_write,
  output logic              busywait,
  output logic [31:0]       load_data,
  output logic              bus_error,
  output logic              misaligned,
  mem_access_unit_if.master dmem
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic        request_s, is_store_s, misaligned_s, timeout_s;
  logic [2:0]  funct3_s, funct3_r;
  logic [1:0]  lane_r;
  logic [7:0]  count_r;
  logic        req_r, we_r, bus_error_r, misaligned_r;
  logic [29:0] addr_r;
  logic [31:0] wdata_r, load_data_r;
  logic [3:0]  be_r;

  // Returns {byte enables, lane-replicated write data}.
  function automatic logic [35:0] store_lanes(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] data);
    case (size)
      2'b00:   store_lanes = {4'b0001 << lane, {4{data[7:0]}}};
      2'b01:   store_lanes = {(lane[1] ? 4'b1100 : 4'b0011), {2{data[15:0]}}};
      default: store_lanes = {4'b1111, data};
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Request decode; a store takes priority over a simultaneous load.
  always_comb begin
    is_store_s = mem_data_mem_write[2];
    request_s  = mem_data_mem_write[2] | mem_data_mem_read[3];
    funct3_s   = is_store_s ? {1'b0, mem_data_mem_write[1:0]} : mem_data_mem_read[2:0];
`ifdef DMEM_MISALIGN_CHECK_EN
    case (funct3_s[1:0])
      2'b01:   misaligned_s = mem_alu_out[0];
      2'b10:   misaligned_s = (mem_alu_out[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
`else
    misaligned_s = 1'b0;
`endif
  end

  // Next-state and stall logic.
  always_comb begin
    next_state_s = state_r;
    busywait     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (request_s) begin
          busywait     = 1'b1;
          next_state_s = misaligned_s ? DONE : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        busywait = 1'b1;
        if (dmem.ack) begin
          next_state_s = DONE;
        end else if (count_r == TIMEOUT - 8'd1) begin
          timeout_s    = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bus outputs, load result, status pulses and the access timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 30'd0;
      wdata_r      <= 32'd0;
      be_r         <= 4'd0;
      funct3_r     <= 3'd0;
      lane_r       <= 2'd0;
      count_r      <= 8'd0;
      load_data_r  <= 32'd0;
      bus_error_r  <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      bus_error_r  <= 1'b0;
      misaligned_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (request_s && !misaligned_s) begin
            req_r    <= 1'b1;
            we_r     <= is_store_s;
            addr_r   <= mem_alu_out[31:2];
            lane_r   <= mem_alu_out[1:0];
            funct3_r <= funct3_s;
            count_r  <= 8'd0;
            if (is_store_s) begin
              {be_r, wdata_r} <= store_lanes(funct3_s[1:0], mem_alu_out[1:0], mem_reg_data2);
            end else begin
              be_r    <= 4'b1111;
              wdata_r <= 32'd0;
            end
          end else if (request_s) begin
            misaligned_r <= 1'b1;
          end else begin
            req_r <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem.ack) begin
            req_r <= 1'b0;
            if (!we_r) begin
              load_data_r <= load_extend(funct3_r, lane_r, dmem.rdata);
            end
          end else if (timeout_s) begin
            req_r       <= 1'b0;
            load_data_r <= 32'd0;
            bus_error_r <= 1'b1;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        default: req_r <= 1'b0;
      endcase
    end
  end

  assign dmem.req    = req_r;
  assign dmem.we     = we_r;
  assign dmem.addr   = addr_r;
  assign dmem.wdata  = wdata_r;
  assign dmem.be     = be_r;
  assign load_data   = load_data_r;
  assign bus_error   = bus_error_r;
  assign misaligned  = misaligned_r;

endmodule
